hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
Pipeline hazard controller for the 5-stage RV32I core. It tracks the destination, write-enable and result-source of in-flight instructions in internal E/M/W shadow registers, which it loads from the decode-stage control outputs. From these it generates the stall, flush and forwarding selects. It also freezes the pipeline while the data-memory handshake is pending and counts stall cycles for performance monitoring.

Parameters:
CNT_W, 32, width of stall_cycles performance counter (saturating)
REG_AW, 5, register address width

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
rs1_d  in  REG_AW  decode-stage source 1 address
rs2_d  in  REG_AW  decode-stage source 2 address
rd_d  in  REG_AW  decode-stage destination address
REG_WRITE_D  in  1  decode-stage register write enable
RES_SRC_D  in  2  decode-stage result source (01 = load)
MEM_WRITE_D  in  1  decode-stage store flag
pc_src_e  in  1  branch/jump taken, resolved in E
dmem_ready_m  in  1  data memory completes the M-stage access this cycle
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID
stall_e  out  1  hold ID/EX
stall_m  out  1  hold EX/MEM
flush_d  out  1  clear IF/ID
flush_e  out  1  clear ID/EX (bubble)
flush_w  out  1  clear MEM/WB (bubble)
forward_a_e  out  2  ALU A source: 00 reg file, 01 W result, 10 M ALU result
forward_b_e  out  2  same for operand B
stall_cycles  out  CNT_W  count of cycles with stall_f=1

Behaviour:
- Shadow state: E{rs1,rs2,rd,rw,load,mem}, M{rd,rw,load,mem}, W{rd,rw}. Reset clears all rw/load/mem bits and addresses to 0. stall_cycles resets to 0. With a cleared shadow, every output is 0 in the first cycle after reset.
- mem_wait = (M.load | M.mem) & ~dmem_ready_m.
- load_use = E.rw & E.load & E.rd!=0 & (E.rd==rs1_d | E.rd==rs2_d). The comparison is conservative and ignores whether the source is actually used.
- Priority, evaluated combinationally each cycle:
  1. mem_wait: stall_f=stall_d=stall_e=stall_m=1, flush_w=1. All other flushes are 0, and pc_src_e is ignored this cycle. E, M and W shadows hold; W receives a bubble (W.rw<=0).
  2. pc_src_e: flush_d=flush_e=1, all stalls 0. E<=bubble, M<=E, W<=M. A simultaneous load_use is discarded.
  3. load_use: stall_f=stall_d=1, flush_e=1. E<=bubble, M<=E, W<=M. The stall lasts exactly 1 cycle because the load leaves E.
  4. Otherwise: E<=D inputs, M<=E, W<=M.
- Forwarding for operand A (B is identical, using rs2):
  - 10 if M.rw & M.rd!=0 & M.rd==E.rs1.
  - Else 01 if W.rw & W.rd!=0 & W.rd==E.rs1.
  - Else 00.
  - M has priority over W.
  - x0 is never forwarded.
  - Forwarding is valid during mem_wait; the shadows are frozen, so the selects stay stable.
- stall_cycles increments when stall_f=1 and saturates at all-ones.
- Reset asserted mid-stall or mid-mem_wait: the next cycle every output is 0 and every shadow is cleared. No pending stall survives reset.

Decomposition:
- Shared package pipe_pkg:
  - RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_PCT=2'b11
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10
- Sub-module fwd_sel: combinational forward-select generator, instantiated twice (A and B), with inputs rs_e, M.rd/rw, W.rd/rw.
- Shadow registers and priority logic stay in hazard_unit.

Test Plan:
- Back-to-back ALU ops: add x5,x1,x2 then sub x6,x5,x3. Expect forward_a_e=10 in the sub's E cycle, then 01 for a dependent third instruction. No stalls.
- Load-use: lw x7 then add x8,x7,x1. Expect exactly one cycle of stall_f=stall_d=flush_e=1, then forward_a_e=01 and stall_cycles=1.
- Taken branch coinciding with load_use (pc_src_e=1 in the same cycle): expect flush_d=flush_e=1, stall_f=0, and stall_cycles unchanged.
- Memory wait: lw in M with dmem_ready_m=0 for 3 cycles. Expect all four stalls plus flush_w for 3 cycles with forward selects constant, then normal advance and stall_cycles +3.
- Writes to x0: lw x0 followed by a use of x0. Expect no stall and forward_*_e=00.
- Reset asserted during a mem_wait cycle: the following cycle all outputs are 0 and stall_cycles=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings for the RV32I hazard controller.
//   RES_*  : decode-stage result-source encodings (RES_MEM marks a load)
//   FWD_*  : forwarding-select encodings for the E-stage ALU operands
package pipe_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_PCT = 2'b11;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // True when the result source selects data memory, i.e. the instruction is a load.
  function automatic logic is_load(input logic [1:0] res_src);
    return res_src == RES_MEM;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-unit bus: decode-stage control, branch/memory status in, and the
// stall/flush/forward controls plus the stall-cycle counter out.
//   master : pipeline side (drives decode fields and status, receives controls)
//   slave  : hazard unit side
interface hazard_unit_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned REG_AW = 5
);

  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic [REG_AW-1:0] rd_d;
  logic              REG_WRITE_D;
  logic [1:0]        RES_SRC_D;
  logic              MEM_WRITE_D;
  logic              pc_src_e;
  logic              dmem_ready_m;

  logic              stall_f;
  logic              stall_d;
  logic              stall_e;
  logic              stall_m;
  logic              flush_d;
  logic              flush_e;
  logic              flush_w;
  logic [1:0]        forward_a_e;
  logic [1:0]        forward_b_e;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output rs1_d, rs2_d, rd_d, REG_WRITE_D, RES_SRC_D, MEM_WRITE_D, pc_src_e, dmem_ready_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    input  forward_a_e, forward_b_e, stall_cycles
  );

  modport slave (
    input  rs1_d, rs2_d, rd_d, REG_WRITE_D, RES_SRC_D, MEM_WRITE_D, pc_src_e, dmem_ready_m,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
    output forward_a_e, forward_b_e, stall_cycles
  );

endinterface

// File: rtl/fwd_sel.sv
// Combinational forward-select for one E-stage ALU operand.
//   rs_e_i        : E-stage source register address
//   m_rd_i/m_rw_i : M-stage destination and write enable
//   w_rd_i/w_rw_i : W-stage destination and write enable
//   fwd_o         : FWD_M, FWD_W or FWD_RF; M wins over W, x0 never forwarded
module fwd_sel
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] m_rd_i,
  input  logic              m_rw_i,
  input  logic [REG_AW-1:0] w_rd_i,
  input  logic              w_rw_i,
  output logic [1:0]        fwd_o
);

  logic m_hit, w_hit;

  always_comb begin
    m_hit = m_rw_i && (m_rd_i != '0) && (m_rd_i == rs_e_i);
    w_hit = w_rw_i && (w_rd_i != '0) && (w_rd_i == rs_e_i);
    if (m_hit) begin
      fwd_o = FWD_M;
    end else if (w_hit) begin
      fwd_o = FWD_W;
    end else begin
      fwd_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV32I pipeline. Keeps E/M/W shadow copies of
// the in-flight instructions' register usage, loaded from decode-stage controls,
// and derives stalls, flushes and forwarding selects from them.
//   clk, reset : core clock, synchronous active-high reset
//   hz_io      : slave side of hazard_unit_if (decode fields, pc_src_e,
//                dmem_ready_m in; stall_*, flush_*, forward_*_e, stall_cycles out)
// Priority: memory wait > taken branch > load-use > normal advance.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave hz_io
);

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              load;
    logic              mem;
  } e_sh_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rw;
    logic              load;
    logic              mem;
  } m_sh_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              rw;
  } w_sh_t;

  e_sh_t            e_q, e_d;
  m_sh_t            m_q, m_d;
  w_sh_t            w_q, w_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_wait, load_use;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w;

  always_comb begin
    mem_wait = (m_q.load || m_q.mem) && !hz_io.dmem_ready_m;
    // Conservative: matches rs1/rs2 even if the decoded instruction ignores them.
    load_use = e_q.rw && e_q.load && (e_q.rd != '0) &&
               ((e_q.rd == hz_io.rs1_d) || (e_q.rd == hz_io.rs2_d));

    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;

    // Default: normal advance of the shadow pipeline.
    e_d.rs1  = hz_io.rs1_d;
    e_d.rs2  = hz_io.rs2_d;
    e_d.rd   = hz_io.rd_d;
    e_d.rw   = hz_io.REG_WRITE_D;
    e_d.load = is_load(hz_io.RES_SRC_D);
    e_d.mem  = hz_io.MEM_WRITE_D;
    m_d.rd   = e_q.rd;
    m_d.rw   = e_q.rw;
    m_d.load = e_q.load;
    m_d.mem  = e_q.mem;
    w_d.rd   = m_q.rd;
    w_d.rw   = m_q.rw;

    if (mem_wait) begin
      // Freeze everything up to M; the W instruction retires and leaves a bubble.
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
      e_d     = e_q;
      m_d     = m_q;
      w_d.rd  = w_q.rd;
      w_d.rw  = 1'b0;
    end else if (hz_io.pc_src_e) begin
      // Wrong-path instructions in D and E are squashed; load_use is moot.
      flush_d = 1'b1;
      flush_e = 1'b1;
      e_d     = '0;
    end else if (load_use) begin
      // One-cycle stall: the load moves to M, after which W forwarding covers it.
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
      e_d     = '0;
    end

    cnt_d = cnt_q;
    if (stall_f && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  fwd_sel #(
    .REG_AW (REG_AW)
  ) u_fwd_a (
    .rs_e_i (e_q.rs1),
    .m_rd_i (m_q.rd),
    .m_rw_i (m_q.rw),
    .w_rd_i (w_q.rd),
    .w_rw_i (w_q.rw),
    .fwd_o  (hz_io.forward_a_e)
  );

  fwd_sel #(
    .REG_AW (REG_AW)
  ) u_fwd_b (
    .rs_e_i (e_q.rs2),
    .m_rd_i (m_q.rd),
    .m_rw_i (m_q.rw),
    .w_rd_i (w_q.rd),
    .w_rw_i (w_q.rw),
    .fwd_o  (hz_io.forward_b_e)
  );

  assign hz_io.stall_f      = stall_f;
  assign hz_io.stall_d      = stall_d;
  assign hz_io.stall_e      = stall_e;
  assign hz_io.stall_m      = stall_m;
  assign hz_io.flush_d      = flush_d;
  assign hz_io.flush_e      = flush_e;
  assign hz_io.flush_w      = flush_w;
  assign hz_io.stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: an instruction-level pipeline model
// (E/M/W slots as an array) checked every cycle, plus directed scenarios with
// literal expectations.
module tb_hazard_unit;
  import pipe_pkg::*;

  localparam int unsigned CntW  = 32;
  localparam int unsigned RegAw = 5;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(CntW), .REG_AW(RegAw)) hz ();

  hazard_unit #(
    .CNT_W  (CntW),
    .REG_AW (RegAw)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .hz_io (hz)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int rs1;
    int rs2;
    int rd;
    bit rw;
    bit ld;
    bit st;
  } ins_t;

  ins_t        slot   [3];  // 0 = E, 1 = M, 2 = W
  ins_t        slot_n [3];
  logic [31:0] cnt   = 0;
  logic [31:0] cnt_n = 0;

  initial begin
    for (int i = 0; i < 3; i++) begin
      slot[i]   = '{0, 0, 0, 1'b0, 1'b0, 1'b0};
      slot_n[i] = '{0, 0, 0, 1'b0, 1'b0, 1'b0};
    end
  end

  function automatic logic [1:0] fwd_of(input int rs);
    if (slot[1].rw && slot[1].rd != 0 && slot[1].rd == rs) return 2'b10;
    if (slot[2].rw && slot[2].rd != 0 && slot[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin : compare
    ins_t dec;
    ins_t bub;
    bit   mw, lu, br;
    bit   e_sf, e_se, e_fd, e_fe;
    dec = '{int'(hz.rs1_d), int'(hz.rs2_d), int'(hz.rd_d), hz.REG_WRITE_D,
            hz.RES_SRC_D == 2'b01, hz.MEM_WRITE_D};
    bub = '{0, 0, 0, 1'b0, 1'b0, 1'b0};
    br  = hz.pc_src_e;
    mw  = (slot[1].ld || slot[1].st) && !hz.dmem_ready_m;
    lu  = slot[0].rw && slot[0].ld && slot[0].rd != 0 &&
          (slot[0].rd == dec.rs1 || slot[0].rd == dec.rs2);
    e_sf = mw || (!br && lu);
    e_se = mw;
    e_fd = !mw && br;
    e_fe = !mw && (br || lu);
    chk("stall_f", 32'(hz.stall_f), 32'(e_sf));
    chk("stall_d", 32'(hz.stall_d), 32'(e_sf));
    chk("stall_e", 32'(hz.stall_e), 32'(e_se));
    chk("stall_m", 32'(hz.stall_m), 32'(e_se));
    chk("flush_d", 32'(hz.flush_d), 32'(e_fd));
    chk("flush_e", 32'(hz.flush_e), 32'(e_fe));
    chk("flush_w", 32'(hz.flush_w), 32'(mw));
    chk("forward_a_e", 32'(hz.forward_a_e), 32'(fwd_of(slot[0].rs1)));
    chk("forward_b_e", 32'(hz.forward_b_e), 32'(fwd_of(slot[0].rs2)));
    chk("stall_cycles", hz.stall_cycles, cnt);

    if (reset) begin
      for (int i = 0; i < 3; i++) slot_n[i] = bub;
      cnt_n = 0;
    end else begin
      if (mw) begin
        for (int i = 0; i < 3; i++) slot_n[i] = slot[i];
        slot_n[2].rw = 1'b0;
      end else begin
        slot_n[2] = slot[1];
        slot_n[1] = slot[0];
        slot_n[0] = (br || lu) ? bub : dec;
      end
      cnt_n = (e_sf && cnt != 32'hFFFF_FFFF) ? cnt + 1 : cnt;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) slot[i] = slot_n[i];
    cnt = cnt_n;
  end

  // ---------------- stimulus ----------------
  // One pipeline cycle: drive decode/status just after the edge, return at negedge.
  task automatic cyc(input int rs1, input int rs2, input int rd, input bit rw,
                     input logic [1:0] res, input bit pc, input bit rdy, input bit rst);
    @(posedge clk);
    #1;
    reset           = rst;
    hz.rs1_d        = RegAw'(rs1);
    hz.rs2_d        = RegAw'(rs2);
    hz.rd_d         = RegAw'(rd);
    hz.REG_WRITE_D  = rw;
    hz.RES_SRC_D    = res;
    hz.MEM_WRITE_D  = 1'b0;
    hz.pc_src_e     = pc;
    hz.dmem_ready_m = rdy;
    @(negedge clk);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1'b0, RES_ALU, 1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] all_outs();
    return {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.flush_d, hz.flush_e,
            hz.flush_w, hz.forward_a_e, hz.forward_b_e} | hz.stall_cycles;
  endfunction

  initial begin
    reset           = 1'b1;
    hz.rs1_d        = '0;
    hz.rs2_d        = '0;
    hz.rd_d         = '0;
    hz.REG_WRITE_D  = 1'b0;
    hz.RES_SRC_D    = RES_ALU;
    hz.MEM_WRITE_D  = 1'b0;
    hz.pc_src_e     = 1'b0;
    hz.dmem_ready_m = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state
    nop(1);
    chk("reset_outputs", all_outs(), 32'h0);

    // Back-to-back ALU: add x5,x1,x2; sub x6,x5,x3; or x9,x5,x6
    cyc(1, 2, 5, 1'b1, RES_ALU, 1'b0, 1'b1, 1'b0);
    cyc(5, 3, 6, 1'b1, RES_ALU, 1'b0, 1'b1, 1'b0);
    cyc(5, 6, 9, 1'b1, RES_ALU, 1'b0, 1'b1, 1'b0);
    chk("alu_fwd_a_m", 32'(hz.forward_a_e), 32'h2);
    chk("alu_no_stall", 32'(hz.stall_f), 32'h0);
    nop(1);
    chk("alu_fwd_a_w", 32'(hz.forward_a_e), 32'h1);
    chk("alu_fwd_b_m", 32'(hz.forward_b_e), 32'h2);
    nop(3);

    // Load-use: lw x7; add x8,x7,x1 (IF/ID holds it for one extra cycle)
    cyc(1, 0, 7, 1'b1, RES_MEM, 1'b0, 1'b1, 1'b0);
    cyc(7, 1, 8, 1'b1, RES_ALU, 1'b0, 1'b1, 1'b0);
    chk("lu_stall_f", 32'(hz.stall_f), 32'h1);
    chk("lu_stall_d", 32'(hz.stall_d), 32'h1);
    chk("lu_flush_e", 32'(hz.flush_e), 32'h1);
    chk("lu_stall_e", 32'(hz.stall_e), 32'h0);
    cyc(7, 1, 8, 1'b1, RES_ALU, 1'b0, 1'b1, 1'b0);
    chk("lu_one_cycle", 32'(hz.stall_f), 32'h0);
    chk("lu_count", hz.stall_cycles, 32'd1);
    nop(1);
    chk("lu_fwd_a_w", 32'(hz.forward_a_e), 32'h1);
    nop(3);

    // Taken branch in the same cycle as a load-use
    cyc(1, 0, 7, 1'b1, RES_MEM, 1'b0, 1'b1, 1'b0);
    cyc(7, 1, 8, 1'b1, RES_ALU, 1'b1, 1'b1, 1'b0);
    chk("br_flush_d", 32'(hz.flush_d), 32'h1);
    chk("br_flush_e", 32'(hz.flush_e), 32'h1);
    chk("br_stall_f", 32'(hz.stall_f), 32'h0);
    nop(1);
    chk("br_count", hz.stall_cycles, 32'd1);
    nop(3);

    // Memory wait: lw x7 sits in M for three not-ready cycles
    cyc(1, 0, 7, 1'b1, RES_MEM, 1'b0, 1'b1, 1'b0);
    cyc(1, 2, 10, 1'b1, RES_ALU, 1'b0, 1'b1, 1'b0);
    cyc(1, 2, 11, 1'b1, RES_ALU, 1'b0, 1'b0, 1'b0);
    chk("mw_stall_m", 32'(hz.stall_m), 32'h1);
    chk("mw_flush_w", 32'(hz.flush_w), 32'h1);
    chk("mw_fwd_a", 32'(hz.forward_a_e), 32'h0);
    cyc(1, 2, 11, 1'b1, RES_ALU, 1'b1, 1'b0, 1'b0);
    chk("mw_stall_f", 32'(hz.stall_f), 32'h1);
    chk("mw_ignores_branch", 32'(hz.flush_d), 32'h0);
    cyc(1, 2, 11, 1'b1, RES_ALU, 1'b0, 1'b0, 1'b0);
    chk("mw_stall_e", 32'(hz.stall_e), 32'h1);
    cyc(1, 2, 11, 1'b1, RES_ALU, 1'b0, 1'b1, 1'b0);
    chk("mw_release", 32'(hz.stall_f), 32'h0);
    chk("mw_count", hz.stall_cycles, 32'd4);
    nop(3);

    // Writes to x0: lw x0; add x8,x0,x0
    cyc(1, 0, 0, 1'b1, RES_MEM, 1'b0, 1'b1, 1'b0);
    cyc(0, 0, 8, 1'b1, RES_ALU, 1'b0, 1'b1, 1'b0);
    chk("x0_no_stall", 32'(hz.stall_f), 32'h0);
    nop(1);
    chk("x0_fwd_a", 32'(hz.forward_a_e), 32'h0);
    chk("x0_fwd_b", 32'(hz.forward_b_e), 32'h0);
    nop(3);

    // Reset asserted during a memory wait
    cyc(1, 0, 7, 1'b1, RES_MEM, 1'b0, 1'b1, 1'b0);
    nop(1);
    cyc(0, 0, 0, 1'b0, RES_ALU, 1'b0, 1'b0, 1'b0);
    chk("rst_mw_pre", 32'(hz.stall_f), 32'h1);
    cyc(0, 0, 0, 1'b0, RES_ALU, 1'b0, 1'b0, 1'b1);
    cyc(0, 0, 0, 1'b0, RES_ALU, 1'b0, 1'b0, 1'b0);
    chk("rst_mw_outputs", all_outs(), 32'h0);
    chk("rst_mw_count", hz.stall_cycles, 32'd0);
    nop(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
